// File: rtl/render_frame_sched_pkg.sv
// Shared types and defaults for the render frame scheduler.
// Holds the FSM state type, default widths and a saturating helper.
package render_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RENDER,
    ST_WAIT
  } state_e;

  localparam int TIMER_W_DEF     = 32;
  localparam int WDOG_CYCLES_DEF = 2_000_000;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/render_frame_sched_if.sv
// Scheduler <-> renderer/display signal bundle.
// master: the scheduler side; slave: renderers, display and control.
interface render_frame_sched_if #(
  parameter int NUM_RENDERERS = 2,
  parameter int TIMER_W       = 32
);

  logic                     enable;
  logic                     new_frame;
  logic [NUM_RENDERERS-1:0] done;
  logic                     start;
  logic [TIMER_W-1:0]       timer;
  logic                     buf_sel;
  logic                     busy;
  logic                     timeout;
  logic [7:0]               dropped;

  modport master (
    input  enable, new_frame, done,
    output start, timer, buf_sel,
    output busy, timeout, dropped
  );

  modport slave (
    output enable, new_frame, done,
    input  start, timer, buf_sel,
    input  busy, timeout, dropped
  );

endinterface

// File: rtl/render_frame_sched.sv
// Frame sequencer: starts renderers, waits for completion, swaps on vsync.
// In: clk_in, rst_in(async low), enable_in, new_frame_in, done_in[N].
// Out: start_out, timer_out, buf_sel_out, busy_out, timeout_out,
//      dropped_out -- all registered.
module render_frame_sched
  import render_pkg::*;
#(
  parameter int NUM_RENDERERS = 2,
  parameter int TIMER_W       = TIMER_W_DEF,
  parameter int WDOG_CYCLES   = WDOG_CYCLES_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable_in,
  input  logic                     new_frame_in,
  input  logic [NUM_RENDERERS-1:0] done_in,
  output logic                     start_out,
  output logic [TIMER_W-1:0]       timer_out,
  output logic                     buf_sel_out,
  output logic                     busy_out,
  output logic                     timeout_out,
  output logic [7:0]               dropped_out
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(WDOG_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [NUM_RENDERERS-1:0] lat_q, lat_d;
  logic [NUM_RENDERERS-1:0] prev_q;
  logic [NUM_RENDERERS-1:0] lat_nx;
  logic [WD_W-1:0]          wd_q, wd_d, wd_inc;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic                     buf_q, buf_d;
  logic                     to_q, to_d;
  logic [7:0]               drop_q, drop_d;
  logic                     start_q, busy_q;
  logic                     all_done, swap;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    wd_d    = wd_q;
    timer_d = timer_q;
    buf_d   = buf_q;
    to_d    = to_q;
    drop_d  = drop_q;
    swap    = 1'b0;
    // only fresh rising edges count; a level held over from
    // before RENDER is masked by prev_q
    lat_nx   = lat_q | (done_in & ~prev_q);
    all_done = &lat_nx;
    wd_inc   = wd_q + WD_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (enable_in) state_d = ST_START;
      end
      ST_START: begin
        lat_d   = '0;
        wd_d    = '0;
        state_d = ST_RENDER;
      end
      ST_RENDER: begin
        lat_d = lat_nx;
        wd_d  = wd_inc;
        // completion on the vsync cycle itself is on time
        if (all_done && new_frame_in) begin
          swap = 1'b1;
        end else begin
          if (new_frame_in) drop_d = sat_inc8(drop_q);
          if (all_done) begin
            state_d = ST_WAIT;
          end else if (wd_inc == WD_LAST) begin
            to_d    = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (new_frame_in) swap = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (swap) begin
      buf_d   = ~buf_q;
      timer_d = timer_q + TIMER_W'(1);
      state_d = enable_in ? ST_START : ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      prev_q  <= '0;
      wd_q    <= '0;
      timer_q <= '0;
      buf_q   <= 1'b0;
      to_q    <= 1'b0;
      drop_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      prev_q  <= done_in;
      wd_q    <= wd_d;
      timer_q <= timer_d;
      buf_q   <= buf_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
      start_q <= (state_d == ST_START);
      busy_q  <= (state_d == ST_START) ||
                 (state_d == ST_RENDER);
    end
  end

  assign start_out   = start_q;
  assign timer_out   = timer_q;
  assign buf_sel_out = buf_q;
  assign busy_out    = busy_q;
  assign timeout_out = to_q;
  assign dropped_out = drop_q;

endmodule

// File: tb/tb_render_frame_sched.sv
// Scoreboard bench for render_frame_sched.
// Stimulus pushes expected swap records; a monitor checks each swap.
module tb_render_frame_sched;

  localparam int N  = 2;
  localparam int TW = 32;
  localparam int WD = 1000;

  typedef struct packed {
    logic [31:0] timer;
    logic        buf_sel;
    logic [7:0]  dropped;
    logic        timeout;
    logic        start;
  } swap_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  render_frame_sched_if #(
    .NUM_RENDERERS(N), .TIMER_W(TW)
  ) bus ();

  render_frame_sched #(
    .NUM_RENDERERS(N),
    .TIMER_W(TW),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .enable_in   (bus.enable),
    .new_frame_in(bus.new_frame),
    .done_in     (bus.done),
    .start_out   (bus.start),
    .timer_out   (bus.timer),
    .buf_sel_out (bus.buf_sel),
    .busy_out    (bus.busy),
    .timeout_out (bus.timeout),
    .dropped_out (bus.dropped)
  );

  swap_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function void chk(string nm, logic [31:0] act,
                    logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  logic [31:0] prev_timer = '0;
  logic        prev_start = 1'b0;
  logic        prev_nf    = 1'b0;
  int          n_start    = 0;

  always @(negedge clk) begin
    swap_t e;
    if (rst_n && bus.timer !== prev_timer) begin
      if (exp_q.size() == 0) begin
        chk("swap_unexpected", bus.timer, prev_timer);
      end else begin
        e = exp_q.pop_front();
        chk("swap_timer", bus.timer, e.timer);
        chk("swap_buf", bus.buf_sel, e.buf_sel);
        chk("swap_dropped", bus.dropped, e.dropped);
        chk("swap_timeout", bus.timeout, e.timeout);
        chk("swap_start", bus.start, e.start);
        chk("swap_latency", prev_nf, 1);
      end
    end
    if (rst_n && bus.start) begin
      n_start++;
      chk("start_width", prev_start, 0);
    end
    prev_timer = bus.timer;
    prev_start = bus.start;
    prev_nf    = bus.new_frame;
  end

  // ---------------- stimulus ----------------
  int cyc   = 0;
  int fcnt  = 0;
  int per   = 100;
  int cnt   = 0;
  int s_cyc = 0;
  int saved = 0;
  int dly[2];
  bit stale = 1'b0;

  // one clock; renderer model and vsync generator
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (bus.start) begin
      cnt   = 0;
      s_cyc = cyc;
      if (!stale) bus.done = '0;
    end else begin
      cnt++;
    end
    if (stale) begin
      bus.done = (cnt >= 30 && cnt < 150) ? 2'b00 : 2'b11;
    end else begin
      for (int i = 0; i < N; i++)
        if (cnt >= dly[i]) bus.done[i] = 1'b1;
    end
    fcnt++;
    bus.new_frame = (fcnt == per);
    if (fcnt == per) fcnt = 0;
  endtask

  task automatic run_pulses(int n);
    int k = 0;
    while (k < n) begin
      tick();
      if (bus.new_frame) k++;
    end
  endtask

  task automatic push(int t, bit b, int d, bit to, bit st);
    swap_t e;
    e.timer   = t;
    e.buf_sel = b;
    e.dropped = 8'(d);
    e.timeout = to;
    e.start   = st;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(string pfx);
    chk({pfx, "_start"}, bus.start, 0);
    chk({pfx, "_timer"}, bus.timer, 0);
    chk({pfx, "_buf"}, bus.buf_sel, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_timeout"}, bus.timeout, 0);
    chk({pfx, "_dropped"}, bus.dropped, 0);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.new_frame = 1'b0;
    bus.done      = '0;
    dly           = '{20, 20};
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // nominal: done after 20, vsync every 100
    push(1, 1, 0, 0, 1);
    push(2, 0, 0, 0, 1);
    push(3, 1, 0, 0, 1);
    fcnt = 0;
    bus.enable = 1'b1;
    run_pulses(3);
    chk("nominal_starts", n_start, 3);

    // slow renderer: two drops per frame
    dly = '{20, 250};
    push(4, 0, 2, 0, 1);
    push(5, 1, 4, 0, 1);
    run_pulses(6);

    // final done edge coincides with vsync
    dly = '{20, 99};
    push(6, 0, 4, 0, 1);
    push(7, 1, 4, 0, 1);
    run_pulses(2);

    // watchdog: renderer 0 never finishes
    dly = '{100000, 20};
    tick();
    while (cyc < s_cyc + 999) tick();
    chk("timeout_early", bus.timeout, 0);
    tick();
    chk("timeout_at_1000", bus.timeout, 1);
    chk("wdog_dropped", bus.dropped, 14);
    push(8, 0, 14, 1, 1);
    run_pulses(1);

    // stale done held high across start
    bus.done = 2'b11;
    stale = 1'b1;
    push(9, 1, 15, 1, 1);
    run_pulses(2);
    stale = 1'b0;
    dly = '{20, 20};

    // disable mid-RENDER: one more swap, then idle
    tick();
    while (cyc < s_cyc + 10) tick();
    bus.enable = 1'b0;
    push(10, 0, 15, 1, 0);
    run_pulses(1);
    saved = n_start;
    run_pulses(2);
    chk("disable_no_start", n_start, saved);
    chk("disable_busy", bus.busy, 0);

    // reset mid-RENDER
    fcnt = 0;
    bus.enable = 1'b1;
    tick();
    while (cyc < s_cyc + 10) tick();
    chk("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    fcnt = 0;
    push(1, 1, 0, 0, 1);
    run_pulses(1);
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
